piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out serializer: the transmit end of the team's serial-in, parallel-out shift-register link. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, MSB first. A downstream serial-in shift register that clocks `ser_out` on the same `clk` holds the original word, bit for bit, after WIDTH shifts. It sits between a parallel producer and the serial data line.

## Interface
- `WIDTH`, default 4: word length in bits; legal values are 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `load_valid`  input  1: producer offers `load_data` this cycle.
- `load_data`  input  WIDTH: word to transmit; sampled only on acceptance.
- `load_ready`  output  1: serializer can accept a word this cycle.
- `shift_en`  input  1: when high, the serializer advances one bit per clock; when low, it stalls.
- `ser_out`  output  1: serial data bit, registered.
- `ser_valid`  output  1: `ser_out` carries a payload bit this cycle.
- `ser_last`  output  1: `ser_out` carries bit 0, the final bit of the word.

## Operation
- **States:** IDLE and SHIFT. Internal state is a WIDTH-bit shift register `sreg` plus a bit counter `cnt` of width clog2(WIDTH).
- **Acceptance:** a word is accepted at a rising edge when `load_valid && load_ready`.
- **`load_ready` is combinational:**
  - 1 in IDLE.
  - 1 in SHIFT only when `ser_last && shift_en`. This lets the next word follow without a gap.
  - 0 otherwise.
- **IDLE + accept:**
  - `sreg` <= `load_data`, `cnt` <= WIDTH-1.
  - Next state is SHIFT.
  - `ser_out` <= `load_data[WIDTH-1]`, `ser_valid` <= 1.
  - `ser_last` <= 0. Because WIDTH >= 2, the first bit is never the last.
- **SHIFT with `shift_en`=1 and `cnt` > 0:**
  - `cnt` <= `cnt`-1 and `sreg` shifts left.
  - `ser_out` <= next lower bit.
  - `ser_last` <= 1 when the new `cnt` == 0.
- **SHIFT with `shift_en`=1 and `cnt` == 0 (end of word):**
  - If a word is accepted at this edge, load it exactly as from IDLE. State stays SHIFT.
  - Otherwise go to IDLE with `ser_valid` <= 0, `ser_last` <= 0, `ser_out` <= 0.
- **SHIFT with `shift_en`=0:** every register holds. `ser_out`, `ser_valid` and `ser_last` stay stable.
- **`shift_en` in IDLE:** ignored. Loading from IDLE does not require `shift_en`.
- **`load_data` outside acceptance:** ignored. Changes to `load_data` after acceptance do not affect the word in flight.
- **Reset:** asserting `rst_n` low at any time, including mid-word, has these effects:
  - The frame is aborted and the state goes to IDLE.
  - `sreg` = 0, `cnt` = 0.
  - `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0, all immediately and without waiting for a clock.
  - `load_ready` = 1 while in reset and after release.
  - The first acceptance after reset is possible at the first rising edge where `rst_n` is high.

## Timing
- **Latency:** a word accepted at edge k puts its MSB on `ser_out` during cycle k+1. With `shift_en` held high, bit i appears during cycle k+WIDTH-i.
- **Frame length:** a frame occupies exactly WIDTH enabled cycles with `ser_valid` = 1. `ser_last` is high only in the final one.
- **Back-to-back throughput:** one bit per clock with no idle cycle between words. The next word is accepted at the edge that ends the `ser_last` cycle.
- **Stall:** each low cycle of `shift_en` during SHIFT stretches the frame by one cycle. The data sequence does not change.
- **Output timing:** all outputs except `load_ready` are flop outputs with no combinational path from the inputs.

## Test plan
- **Reset values:** hold `rst_n` low, then release → `ser_out`, `ser_valid` and `ser_last` are 0 and `load_ready` is 1. Then load 4'b1011 with `shift_en`=1 → `ser_out` reads 1,0,1,1 in cycles k+1..k+4, `ser_last` is high only in cycle k+4, and `ser_valid` falls at k+5.
- **Round trip:** connect `ser_out` to a 4-bit serial-in shift register on the same `clk` and load 4'hA → the receiver's parallel output equals 4'hA after the 4th shift edge.
- **Back-to-back:** present 4'h3 then 4'hC, with `load_valid` high continuously → 8 consecutive valid bits 0,0,1,1,1,1,0,0. `load_ready` is high only in IDLE and in the two `ser_last` cycles.
- **Stall:** load 4'b1001 and drop `shift_en` for 2 cycles after the second bit → the bit 0 is held for 3 cycles, the sequence is 1,0,0,1 and the frame is 6 cycles long. `load_ready` is 0 if `ser_last` is held with `shift_en`=0.
- **Reset mid-frame:** assert `rst_n` low asynchronously (between edges) during bit 2 → all outputs go to 0 at once. A new load of 4'h5 after release transmits 0,1,0,1 cleanly.
- **Ignored load:** pulse `load_valid` with 4'hF in the middle of a frame → not accepted, and the in-flight word is unaltered.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word over valid/ready
// and shifts it out MSB first, one bit per enabled clock.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt_reg;
  logic             accept;

  // Ready during the final bit lets the next word follow with no gap.
  assign load_ready = (state_reg == IDLE) || (ser_last && shift_en);
  assign accept     = load_valid && load_ready;
  assign sreg_next  = sreg_reg << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= SHIFT;
            sreg_reg  <= load_data;
            cnt_reg   <= CW'(WIDTH - 1);
            ser_out   <= load_data[WIDTH-1];
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt_reg != '0) begin
              cnt_reg  <= cnt_reg - 1'b1;
              sreg_reg <= sreg_next;
              ser_out  <= sreg_next[WIDTH-1];
              ser_last <= (cnt_reg == CW'(1));
            end else if (accept) begin
              // End of word with a new one waiting: reload in place.
              sreg_reg  <= load_data;
              cnt_reg   <= CW'(WIDTH - 1);
              ser_out   <= load_data[WIDTH-1];
              ser_valid <= 1'b1;
              ser_last  <= 1'b0;
            end else begin
              state_reg <= IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4): reset, framing, back-to-back,
// stall, mid-frame reset, ignored loads and a receiver round trip.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic       shift_en;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic [3:0] rx;

  int checks = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last)
  );

  always #5 clk = ~clk;

  // Downstream serial-in receiver on the same clock.
  always_ff @(posedge clk) begin
    if (ser_valid && shift_en) rx <= {rx[2:0], ser_out};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ser_out"}, 32'(ser_out), 32'd0);
    check({tag, ".ser_valid"}, 32'(ser_valid), 32'd0);
    check({tag, ".ser_last"}, 32'(ser_last), 32'd0);
    check({tag, ".load_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Send one word with shift_en held high; check every bit and the return to idle.
  task automatic send_word(input string tag, input logic [3:0] word);
    load_data  = word;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    #1;
    check({tag, ".ready_idle"}, 32'(load_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      load_valid = 1'b0;
      check($sformatf("%s.bit%0d", tag, i), 32'(ser_out), 32'(word[3-i]));
      check($sformatf("%s.valid%0d", tag, i), 32'(ser_valid), 32'd1);
      check($sformatf("%s.last%0d", tag, i), 32'(ser_last), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("%s.ready%0d", tag, i), 32'(load_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check_idle({tag, ".end"});
    $display("word %s data=%h sent", tag, word);
  endtask

  initial begin
    logic [7:0] b2b;
    logic [5:0] stall_out;
    logic [5:0] stall_en;
    logic [3:0] ign;

    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = 4'h0;
    shift_en   = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_idle("reset_held");
    rst_n = 1'b1;
    tick();
    check_idle("reset_released");

    // Basic frame, then the receiver must hold the word.
    send_word("w1011", 4'b1011);
    check("rx_1011", 32'(rx), 32'hB);
    send_word("roundtrip", 4'hA);
    check("rx_A", 32'(rx), 32'hA);

    // Back-to-back 3 then C with load_valid high throughout.
    b2b        = 8'b0011_1100;
    load_data  = 4'h3;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    #1;
    check("b2b.ready_idle", 32'(load_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      load_data = 4'hC;
      check($sformatf("b2b.bit%0d", i), 32'(ser_out), 32'(b2b[7-i]));
      check($sformatf("b2b.valid%0d", i), 32'(ser_valid), 32'd1);
      check($sformatf("b2b.last%0d", i), 32'(ser_last), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      check($sformatf("b2b.ready%0d", i), 32'(load_ready), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      if (i == 7) load_valid = 1'b0;
    end
    tick();
    check_idle("b2b.end");
    $display("word b2b data=3,C sent");

    // Stall: shift_en low during cycles 2 and 3 of the frame.
    stall_out  = 6'b100001;
    stall_en   = 6'b100110;
    load_data  = 4'b1001;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load_valid = 1'b0;
      check($sformatf("stall.bit%0d", i), 32'(ser_out), 32'(stall_out[5-i]));
      check($sformatf("stall.valid%0d", i), 32'(ser_valid), 32'd1);
      check($sformatf("stall.last%0d", i), 32'(ser_last), (i == 5) ? 32'd1 : 32'd0);
      shift_en = stall_en[5-i];
      #1;
      check($sformatf("stall.ready%0d", i), 32'(load_ready), (i == 5) ? 32'd0 : 32'd0);
    end
    // Final bit held while stalled; a waiting word must not be taken.
    load_valid = 1'b1;
    load_data  = 4'hF;
    #1;
    check("stall.ready_last_held", 32'(load_ready), 32'd0);
    tick();
    check("stall.held_out", 32'(ser_out), 32'd1);
    check("stall.held_last", 32'(ser_last), 32'd1);
    check("stall.held_valid", 32'(ser_valid), 32'd1);
    load_valid = 1'b0;
    shift_en   = 1'b1;
    #1;
    check("stall.ready_last_en", 32'(load_ready), 32'd1);
    tick();
    check_idle("stall.end");
    $display("word stall data=9 sent");

    // Asynchronous reset during bit 2 of 4'h6.
    load_data  = 4'h6;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    check("rstmid.bit2_before", 32'(ser_out), 32'd1);
    check("rstmid.valid_before", 32'(ser_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rstmid.async");
    #1 rst_n = 1'b1;
    $display("word rstmid data=6 aborted");
    send_word("after_reset", 4'h5);

    // Load offered mid-frame is ignored; in-flight word 4'h2 is unchanged.
    ign        = 4'h2;
    load_data  = ign;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    check("ignore.bit0", 32'(ser_out), 32'(ign[3]));
    tick();
    check("ignore.bit1", 32'(ser_out), 32'(ign[2]));
    load_valid = 1'b1;
    load_data  = 4'hF;
    #1;
    check("ignore.ready", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    load_data  = 4'h0;
    check("ignore.bit2", 32'(ser_out), 32'(ign[1]));
    tick();
    check("ignore.bit3", 32'(ser_out), 32'(ign[0]));
    check("ignore.last", 32'(ser_last), 32'd1);
    tick();
    check_idle("ignore.end");
    check("ignore.rx", 32'(rx), 32'h2);
    $display("word ignore data=2 sent");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
